// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: frames SYNC/LEN/data bytes into big-endian words for the IM write port.
// Define IM_LOADER_CHKSUM_EN to require a trailing XOR checksum byte on every frame.
module im_loader #(
  parameter int          NMEM      = 20,
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] im_add,
  output logic [31:0] im_data,
  output logic        im_en,
  output logic        im_rd_wr,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE} state_t;

  localparam logic [15:0] NMEM_W = 16'(NMEM);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] words_left;
  logic [1:0]  byte_cnt;
  logic [23:0] word;
  logic [31:0] addr;
  logic        accept;
  logic [15:0] len;

  assign accept = rx_valid && rx_ready;
  assign len    = {len_hi, rx_data};

`ifdef IM_LOADER_CHKSUM_EN
  // Running XOR over length and data bytes; restarts whenever the loader is idle.
  logic [7:0] chk;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE)
      chk <= 8'd0;
    else if (accept && (state == LEN_HI || state == LEN_LO || state == DATA))
      chk <= chk ^ rx_data;
  end
`endif

  // rx_ready is registered alongside each transition so it tracks the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      im_add     <= 32'd0;
      im_data    <= 32'd0;
      im_en      <= 1'b0;
      im_rd_wr   <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len_hi     <= 8'd0;
      words_left <= 16'd0;
      byte_cnt   <= 2'd0;
      word       <= 24'd0;
      addr       <= BASE_ADDR;
    end else begin
      im_en    <= 1'b0;
      im_rd_wr <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (accept && rx_data == SYNC) begin
            state    <= LEN_HI;
            cpu_hold <= 1'b1;
            err      <= 1'b0;
            addr     <= BASE_ADDR;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            if (len > NMEM_W) begin
              err      <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= IDLE;
            end else if (len == 16'd0) begin
`ifdef IM_LOADER_CHKSUM_EN
              state <= CHK;
`else
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              rx_ready <= 1'b0;
`endif
            end else begin
              words_left <= len;
              byte_cnt   <= 2'd0;
              state      <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_en    <= 1'b1;
              im_rd_wr <= 1'b1;
              im_add   <= addr;
              im_data  <= {word, rx_data};
              rx_ready <= 1'b0;
              state    <= WRITE;
            end else begin
              word <= {word[15:0], rx_data};
            end
          end
        end
        WRITE: begin
          addr       <= addr + 32'd4;
          words_left <= words_left - 16'd1;
          if (words_left == 16'd1) begin
`ifdef IM_LOADER_CHKSUM_EN
            rx_ready <= 1'b1;
            state    <= CHK;
`else
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= DONE;
`endif
          end else begin
            rx_ready <= 1'b1;
            state    <= DATA;
          end
        end
`ifdef IM_LOADER_CHKSUM_EN
        CHK: begin
          if (accept) begin
            cpu_hold <= 1'b0;
            if (rx_data == chk) begin
              done     <= 1'b1;
              rx_ready <= 1'b0;
              state    <= DONE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
`endif
        DONE: begin
          rx_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          rx_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: framed byte streams with hand-computed IM writes, done/err/hold behaviour.
// Works with or without IM_LOADER_CHKSUM_EN defined.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] im_add;
  logic [31:0] im_data;
  logic        im_en;
  logic        im_rd_wr;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [31:0] wr_add  [16];
  logic [31:0] wr_data [16];

  im_loader dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_add(im_add), .im_data(im_data), .im_en(im_en), .im_rd_wr(im_rd_wr),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one byte after an optional random idle gap; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, input int max_gap);
    int gap;
    int guard;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    while (!rx_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic finish_frame(input logic [7:0] chk_byte, input string tag);
`ifdef IM_LOADER_CHKSUM_EN
    applyStimulus(chk_byte, 0);
`endif
    @(negedge clk);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_hold_drop"}, {31'd0, cpu_hold}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done_single"}, {31'd0, done}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (im_en) begin
        if (wr_cnt < 16) begin
          wr_add[wr_cnt]  = im_add;
          wr_data[wr_cnt] = im_data;
        end
        wr_cnt++;
        checkOutput("im_rd_wr_with_en", {31'd0, im_rd_wr}, 32'd1);
        checkOutput("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] f1 [10];
    logic [7:0] f3 [12];
    f1 = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h10};
    f3 = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h00, 8'hA5, 8'hA5, 8'hFF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    // Reset values
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("rst_im_add", im_add, 32'd0);
    checkOutput("rst_im_data", im_data, 32'd0);
    checkOutput("rst_im_en", {31'd0, im_en}, 32'd0);
    checkOutput("rst_im_rd_wr", {31'd0, im_rd_wr}, 32'd0);
    checkOutput("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

    // Garbage before SYNC is ignored
    applyStimulus(8'h00, 0);
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h13, 0);
    @(negedge clk);
    checkOutput("garbage_no_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("garbage_no_write", wr_cnt, 32'd0);

    // Two-word frame
    applyStimulus(8'hA5, 0);
    @(negedge clk);
    checkOutput("sync_sets_hold", {31'd0, cpu_hold}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(f1[i], 0);
      if (i == 5) begin
        @(negedge clk);
        checkOutput("w0_latency_en", {31'd0, im_en}, 32'd1);
        checkOutput("w0_latency_add", im_add, 32'h0);
        checkOutput("w0_hold_during", {31'd0, cpu_hold}, 32'd1);
      end
    end
    @(negedge clk);
    checkOutput("w1_latency_en", {31'd0, im_en}, 32'd1);
    finish_frame(8'h9B, "f1");
    checkOutput("f1_writes", wr_cnt, 32'd2);
    checkOutput("f1_add0", wr_add[0], 32'h0);
    checkOutput("f1_data0", wr_data[0], 32'h20010005);
    checkOutput("f1_add1", wr_add[1], 32'h4);
    checkOutput("f1_data1", wr_data[1], 32'hAC010010);
    checkOutput("f1_done_count", done_cnt, 32'd1);
    checkOutput("f1_err", {31'd0, err}, 32'd0);

    // Oversize length is rejected
    wr_cnt = 0; done_cnt = 0;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h15, 0);
    @(negedge clk);
    checkOutput("big_err", {31'd0, err}, 32'd1);
    checkOutput("big_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("big_idle_ready", {31'd0, rx_ready}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("big_no_write", wr_cnt, 32'd0);
    checkOutput("big_no_done", done_cnt, 32'd0);

    // Empty frame clears err and completes
    applyStimulus(8'hA5, 0);
    @(negedge clk);
    checkOutput("sync_clears_err", {31'd0, err}, 32'd0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    finish_frame(8'h00, "empty");
    checkOutput("empty_no_write", wr_cnt, 32'd0);

    // Gapped stream with SYNC bytes as payload
    wr_cnt = 0; done_cnt = 0;
    applyStimulus(8'hA5, 2);
    applyStimulus(8'h00, 2);
    applyStimulus(8'h03, 2);
    for (int i = 0; i < 12; i++) applyStimulus(f3[i], 3);
    @(negedge clk);
    checkOutput("gap_last_en", {31'd0, im_en}, 32'd1);
    finish_frame(8'h0B, "gap");
    checkOutput("gap_writes", wr_cnt, 32'd3);
    checkOutput("gap_add0", wr_add[0], 32'h0);
    checkOutput("gap_data0", wr_data[0], 32'hA5123456);
    checkOutput("gap_add1", wr_add[1], 32'h4);
    checkOutput("gap_data1", wr_data[1], 32'h00A5A5FF);
    checkOutput("gap_add2", wr_add[2], 32'h8);
    checkOutput("gap_data2", wr_data[2], 32'hDEADBEEF);
    checkOutput("gap_done_count", done_cnt, 32'd1);

`ifdef IM_LOADER_CHKSUM_EN
    // Bad checksum: word stays written, err raised, no done
    wr_cnt = 0; done_cnt = 0;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h44, 0);
    applyStimulus(8'h46, 0);
    @(negedge clk);
    checkOutput("badchk_err", {31'd0, err}, 32'd1);
    checkOutput("badchk_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("badchk_no_done", done_cnt, 32'd0);
    checkOutput("badchk_writes", wr_cnt, 32'd1);
    checkOutput("badchk_data", wr_data[0], 32'h11223344);
`endif

    // Reset in the middle of a word
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h20, 0);
    applyStimulus(8'h01, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("midrst_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("midrst_im_add", im_add, 32'd0);
    checkOutput("midrst_im_data", im_data, 32'd0);
    checkOutput("midrst_im_en", {31'd0, im_en}, 32'd0);
    checkOutput("midrst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wr_cnt = 0; done_cnt = 0;
    @(negedge clk);
    checkOutput("post_rst_ready", {31'd0, rx_ready}, 32'd1);
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    finish_frame(8'h00, "post_rst");
    checkOutput("post_rst_no_write", wr_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time instruction-memory loader for the five-stage pipeline. Accepts a framed byte stream from a serial byte receiver, assembles big-endian 32-bit instruction words, and drives the instruction-memory write port (`im_add`, `im_data`, `im_en`, `im_rd_wr`). It holds the CPU off while loading and reports completion or error. It is the initiator for the IM load port the CPU exposes.

## Interface
- `NMEM`, 20: capacity of instruction memory in words; frames longer than this are rejected.
- `BASE_ADDR`, 32'd0: byte address of the first loaded word.
- `SYNC`, 8'hA5: frame start byte.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid this cycle.
- `rx_ready`  out  1  loader accepts a byte; transfer occurs when `rx_valid && rx_ready`.
- `im_add`  out  32  IM byte address being written.
- `im_data`  out  32  instruction word being written.
- `im_en`  out  1  one-cycle IM write strobe.
- `im_rd_wr`  out  1  1 = write; driven 1 only with `im_en`, else 0.
- `cpu_hold`  out  1  CPU must stall/hold PC at 0 while high.
- `done`  out  1  one-cycle pulse on successful frame end.
- `err`  out  1  sticky error flag; cleared by the next accepted SYNC or by `rst`.

## Operation
- Frame: SYNC, LEN_HI, LEN_LO (16-bit word count N), then 4·N data bytes (MSB first per word), then optional CHK byte.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE.
- IDLE: `rx_ready`=1; bytes other than SYNC are discarded; SYNC → LEN_HI, sets `cpu_hold`, clears `err`, sets word address to `BASE_ADDR`, clears running checksum.
- LEN_HI/LEN_LO: capture N. After LEN_LO: N > NMEM → set `err`, drop `cpu_hold`, return to IDLE, no IM writes. N = 0 → CHK (or DONE without checksum). Otherwise → DATA with byte counter 0.
- DATA: shift byte into word register (first byte → bits [31:24]); counter 0..3; on 4th byte → WRITE.
- WRITE: `rx_ready`=0; `im_en`=1, `im_rd_wr`=1, `im_add`=current address, `im_data`=assembled word for exactly one cycle; address += 4 (wraps mod 2^32); remaining-word count −1; count reaches 0 → CHK/DONE, else → DATA.
- DONE: `done`=1 for one cycle, `cpu_hold` falls the same cycle, → IDLE.
- SYNC bytes inside a frame are data, not restarts.
- `rst` at any point: state IDLE, all outputs to reset values; partially written IM contents are left as is.

## Timing
- Reset values: `rx_ready`=0 during the reset cycle, then 1 in IDLE; `im_add`=0, `im_data`=0, `im_en`=0, `im_rd_wr`=0, `cpu_hold`=0, `done`=0, `err`=0.
- All outputs registered; `rx_ready` is a function of state only (no combinational path from `rx_valid`).
- Word latency: IM write strobe occurs the cycle after the 4th byte of the word is accepted.
- Minimum frame time with back-to-back bytes: 3 + 5·N (+1 CHK) + 1 cycles.
- `rx_valid` low stalls any byte-consuming state indefinitely; there is no timeout.

## Configuration
- `IM_LOADER_CHKSUM_EN` defined: the CHK state is present. The running XOR covers LEN_HI, LEN_LO and all data bytes. A CHK byte equal to the running XOR → DONE. Any other value → set `err`, no `done` pulse, drop `cpu_hold`, → IDLE. Words already written remain in IM.
- Not defined: no CHK state; after the last WRITE (or after LEN_LO when N = 0) → DONE directly.

## Test plan
- Reset then A5 00 02 20 01 00 05 AC 01 00 10 (plus CHK 0x9B if enabled) → two IM writes: (0x0, 0x20010005), (0x4, 0xAC010010); one `done` pulse; `cpu_hold` high from the cycle after A5 through `done`.
- Garbage bytes 00 FF 13 before A5 → ignored; no IM writes; `cpu_hold` stays 0 until A5 is accepted.
- Frame A5 00 15 (N = 21 > NMEM = 20) → `err`=1, zero IM writes, `cpu_hold`=0, back in IDLE; a following valid frame clears `err`.
- A5 00 00 → no writes; `done` pulses (after CHK 0x00 if enabled).
- `rx_valid` toggled randomly mid-word, with A5 occurring as a data byte → words assembled correctly; exactly one `im_en` cycle per word with `rx_ready`=0 during it.
- With `IM_LOADER_CHKSUM_EN`, bad CHK → `err`=1, no `done`; `rst` asserted mid-DATA → all outputs at reset values the next cycle.
